// File: rtl/mem_cmd_arbiter_pkg.sv
// Shared definitions for the memory command arbiter: FSM state encoding,
// AXI burst-type encodings and the round-robin helper.
package mem_cmd_arbiter_pkg;

    // Arbiter FSM states. There is only ever one burst in flight, so the write
    // and read paths each get an issue state and a wait state.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_WR = 3'd1,
        WAIT_WR  = 3'd2,
        ISSUE_RD = 3'd3,
        WAIT_RD  = 3'd4
    } arb_state_e;

    // AXI AxBURST encodings.
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    // Encoding of the "last served" round-robin flag.
    localparam logic SERVED_RD = 1'b0;
    localparam logic SERVED_WR = 1'b1;

    // True when the writer should be granted from IDLE. With only one
    // requester active it wins outright; with both active the one that was
    // not served last wins.
    function automatic logic pick_writer(input logic wr_req,
                                         input logic rd_req,
                                         input logic last_served);
        return wr_req && (!rd_req || (last_served == SERVED_RD));
    endfunction

endpackage

// File: rtl/burst_watchdog.sv
// Per-burst watchdog: counts cycles spent waiting on a burst and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module burst_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_limit;

    assign at_limit = (count_q == LIMIT);
    assign expired  = enable && at_limit;

    // Clear has priority; the count parks at the limit rather than wrapping
    // so a stalled owner cannot see a second spurious expiry.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !at_limit) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Round-robin arbiter between a write and a read requester in front of an
// AXI master. One burst is outstanding at a time; completion is observed on
// the B channel (writes) or the last R beat (reads), with a watchdog that
// abandons a burst that never completes.
module mem_cmd_arbiter
    import mem_cmd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Write requester
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_len,
    input  logic [2:0]            wr_size,
    input  logic [1:0]            wr_burst,

    // Read requester
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           rd_len,
    input  logic [2:0]            rd_size,
    input  logic [1:0]            rd_burst,

    // Requester handshakes
    output logic                  wr_grant,
    output logic                  rd_grant,
    output logic                  wr_done,
    output logic                  rd_done,

    // Commands to the AXI master
    output logic                  start_write,
    output logic                  start_read,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [31:0]           write_len,
    output logic [2:0]            write_size,
    output logic [1:0]            write_burst,
    output logic [ID_WIDTH-1:0]   write_id,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [31:0]           read_len,
    output logic [2:0]            read_size,
    output logic [1:0]            read_burst,
    output logic [ID_WIDTH-1:0]   read_id,

    // AXI completion observation
    input  logic                  bvalid,
    input  logic                  bready,
    input  logic                  rvalid,
    input  logic                  rready,
    input  logic                  rlast,
    output logic                  timeout_err
);

    arb_state_e            state_q, state_d;
    logic                  last_served_q, last_served_d;

    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [31:0]           write_len_q, write_len_d;
    logic [2:0]            write_size_q, write_size_d;
    logic [1:0]            write_burst_q, write_burst_d;
    logic [ID_WIDTH-1:0]   write_id_q, write_id_d;

    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic [31:0]           read_len_q, read_len_d;
    logic [2:0]            read_size_q, read_size_d;
    logic [1:0]            read_burst_q, read_burst_d;
    logic [ID_WIDTH-1:0]   read_id_q, read_id_d;

    logic                  wr_done_q, wr_done_d;
    logic                  rd_done_q, rd_done_d;
    logic                  timeout_q, timeout_d;

    logic                  wr_complete;
    logic                  rd_complete;
    logic                  wd_clear;
    logic                  wd_enable;
    logic                  wd_expired;

    // Completion qualifiers; they only matter in the matching wait state.
    assign wr_complete = bvalid && bready;
    assign rd_complete = rvalid && rready && rlast;

    // The watchdog restarts while a command is being issued so it reads zero
    // on the first wait cycle, and runs only while waiting.
    assign wd_clear  = (state_q == ISSUE_WR) || (state_q == ISSUE_RD);
    assign wd_enable = (state_q == WAIT_WR)  || (state_q == WAIT_RD);

    burst_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state, command capture, ID advance and pulse generation.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;

        write_addr_d  = write_addr_q;
        write_len_d   = write_len_q;
        write_size_d  = write_size_q;
        write_burst_d = write_burst_q;
        write_id_d    = write_id_q;

        read_addr_d   = read_addr_q;
        read_len_d    = read_len_q;
        read_size_d   = read_size_q;
        read_burst_d  = read_burst_q;
        read_id_d     = read_id_q;

        wr_done_d     = 1'b0;
        rd_done_d     = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_writer(wr_req, rd_req, last_served_q)) begin
                    state_d       = ISSUE_WR;
                    last_served_d = SERVED_WR;
                    write_addr_d  = wr_addr;
                    write_len_d   = wr_len;
                    write_size_d  = wr_size;
                    write_burst_d = wr_burst;
                end else if (rd_req) begin
                    state_d       = ISSUE_RD;
                    last_served_d = SERVED_RD;
                    read_addr_d   = rd_addr;
                    read_len_d    = rd_len;
                    read_size_d   = rd_size;
                    read_burst_d  = rd_burst;
                end
            end

            ISSUE_WR: state_d = WAIT_WR;

            // Completion wins over a coincident watchdog expiry.
            WAIT_WR: begin
                if (wr_complete) begin
                    state_d    = IDLE;
                    wr_done_d  = 1'b1;
                    write_id_d = write_id_q + ID_WIDTH'(1);
                end else if (wd_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end

            ISSUE_RD: state_d = WAIT_RD;

            WAIT_RD: begin
                if (rd_complete) begin
                    state_d   = IDLE;
                    rd_done_d = 1'b1;
                    read_id_d = read_id_q + ID_WIDTH'(1);
                end else if (wd_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, command and pulse registers. Reset leaves the reader as last
    // served so the writer wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= SERVED_RD;
            write_addr_q  <= '0;
            write_len_q   <= '0;
            write_size_q  <= '0;
            write_burst_q <= '0;
            write_id_q    <= '0;
            read_addr_q   <= '0;
            read_len_q    <= '0;
            read_size_q   <= '0;
            read_burst_q  <= '0;
            read_id_q     <= '0;
            wr_done_q     <= 1'b0;
            rd_done_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            write_addr_q  <= write_addr_d;
            write_len_q   <= write_len_d;
            write_size_q  <= write_size_d;
            write_burst_q <= write_burst_d;
            write_id_q    <= write_id_d;
            read_addr_q   <= read_addr_d;
            read_len_q    <= read_len_d;
            read_size_q   <= read_size_d;
            read_burst_q  <= read_burst_d;
            read_id_q     <= read_id_d;
            wr_done_q     <= wr_done_d;
            rd_done_q     <= rd_done_d;
            timeout_q     <= timeout_d;
        end
    end

    // Grant and start are the same single-cycle issue-state decode.
    assign start_write = (state_q == ISSUE_WR);
    assign wr_grant    = (state_q == ISSUE_WR);
    assign start_read  = (state_q == ISSUE_RD);
    assign rd_grant    = (state_q == ISSUE_RD);

    assign wr_done     = wr_done_q;
    assign rd_done     = rd_done_q;
    assign timeout_err = timeout_q;

    assign write_addr  = write_addr_q;
    assign write_len   = write_len_q;
    assign write_size  = write_size_q;
    assign write_burst = write_burst_q;
    assign write_id    = write_id_q;
    assign read_addr   = read_addr_q;
    assign read_len    = read_len_q;
    assign read_size   = read_size_q;
    assign read_burst  = read_burst_q;
    assign read_id     = read_id_q;

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Scoreboard bench for mem_cmd_arbiter: directed stimulus pushes the
// expected start/done/timeout events (with their exact cycle); a negedge
// monitor pops and compares each event the DUT presents.
module tb_mem_cmd_arbiter;
    import mem_cmd_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int IW = 4;
    localparam int TO = 16;

    localparam int EV_START_WR = 0;
    localparam int EV_START_RD = 1;
    localparam int EV_WR_DONE  = 2;
    localparam int EV_RD_DONE  = 3;
    localparam int EV_TIMEOUT  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [31:0]   wr_len, rd_len;
    logic [2:0]    wr_size, rd_size;
    logic [1:0]    wr_burst, rd_burst;
    logic          bvalid, bready, rvalid, rready, rlast;
    logic          wr_grant, rd_grant, wr_done, rd_done;
    logic          start_write, start_read, timeout_err;
    logic [AW-1:0] write_addr, read_addr;
    logic [31:0]   write_len, read_len;
    logic [2:0]    write_size, read_size;
    logic [1:0]    write_burst, read_burst;
    logic [IW-1:0] write_id, read_id;

    mem_cmd_arbiter #(
        .ADDR_WIDTH     (AW),
        .ID_WIDTH       (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_len      (wr_len),
        .wr_size     (wr_size),
        .wr_burst    (wr_burst),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_len      (rd_len),
        .rd_size     (rd_size),
        .rd_burst    (rd_burst),
        .wr_grant    (wr_grant),
        .rd_grant    (rd_grant),
        .wr_done     (wr_done),
        .rd_done     (rd_done),
        .start_write (start_write),
        .start_read  (start_read),
        .write_addr  (write_addr),
        .write_len   (write_len),
        .write_size  (write_size),
        .write_burst (write_burst),
        .write_id    (write_id),
        .read_addr   (read_addr),
        .read_len    (read_len),
        .read_size   (read_size),
        .read_burst  (read_burst),
        .read_id     (read_id),
        .bvalid      (bvalid),
        .bready      (bready),
        .rvalid      (rvalid),
        .rready      (rready),
        .rlast       (rlast),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int unsigned at;
        logic [31:0] addr;
        logic [31:0] len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_cmd(input int kind, input int unsigned at, input logic [31:0] addr,
                              input logic [31:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] id);
        exp_t e;
        e.kind = kind; e.at = at; e.addr = addr; e.len = len;
        e.size = size; e.burst = burst; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int unsigned at);
        expect_cmd(kind, at, '0, '0, '0, '0, '0);
    endtask

    task automatic observe(input int kind, input logic [31:0] addr, input logic [31:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            check("event_cycle", 64'(cyc), 64'(e.at));
            if (e.kind == EV_START_WR || e.kind == EV_START_RD) begin
                check("cmd_addr", 64'(addr), 64'(e.addr));
                check("cmd_len", 64'(len), 64'(e.len));
                check("cmd_size", 64'(size), 64'(e.size));
                check("cmd_burst", 64'(burst), 64'(e.burst));
                check("cmd_id", 64'(id), 64'(e.id));
            end
        end
    endtask

    // Monitor: sample outputs on the falling edge and hand events to the scoreboard.
    always @(negedge clk) begin
        if (start_write && start_read) begin
            n_checks++;
            n_fail++;
            $display("FAIL one_outstanding: got both starts at cycle %0d, expected one", cyc);
        end
        if ((wr_grant && !start_write) || (rd_grant && !start_read)) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_without_start: got grants %b%b at cycle %0d, expected none", wr_grant, rd_grant, cyc);
        end
        if (start_write) begin
            check("grant_on_start_wr", 64'({wr_grant, rd_grant}), 64'(2'b10));
            observe(EV_START_WR, write_addr, write_len, write_size, write_burst, write_id);
        end
        if (start_read) begin
            check("grant_on_start_rd", 64'({wr_grant, rd_grant}), 64'(2'b01));
            observe(EV_START_RD, read_addr, read_len, read_size, read_burst, read_id);
        end
        if (wr_done)     observe(EV_WR_DONE, '0, '0, '0, '0, '0);
        if (rd_done)     observe(EV_RD_DONE, '0, '0, '0, '0, '0);
        if (timeout_err) observe(EV_TIMEOUT, '0, '0, '0, '0, '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic set_wr(input logic [31:0] a, input logic [31:0] l, input logic [2:0] s, input logic [1:0] b);
        wr_addr = a; wr_len = l; wr_size = s; wr_burst = b;
    endtask

    task automatic set_rd(input logic [31:0] a, input logic [31:0] l, input logic [2:0] s, input logic [1:0] b);
        rd_addr = a; rd_len = l; rd_size = s; rd_burst = b;
    endtask

    task automatic set_b(input logic v);
        bvalid = v; bready = v;
    endtask

    task automatic set_r(input logic v);
        rvalid = v; rready = v; rlast = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, 64'({wr_grant, rd_grant, wr_done, rd_done, start_write, start_read, timeout_err}), 64'(0));
        check({tag, "_write_cmd"}, {write_addr, write_len}, 64'(0));
        check({tag, "_read_cmd"}, {read_addr, read_len}, 64'(0));
        check({tag, "_misc"}, 64'({write_size, write_burst, read_size, read_burst, write_id, read_id}), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected finish by 100000");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned c;
        wr_req = 0; rd_req = 0;
        set_wr('0, '0, '0, '0);
        set_rd('0, '0, '0, '0);
        set_b(0);
        set_r(0);

        // Reset state
        tick(); tick(); tick();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        tick(); tick();
        check_all_zero("after_reset");

        // Single write: start one cycle after request, done one cycle after B
        c = cyc;
        set_wr(32'h0, 32'd3, 3'd2, BURST_INCR); wr_req = 1;
        expect_cmd(EV_START_WR, c + 1, 32'h0, 32'd3, 3'd2, BURST_INCR, 4'd0);
        goto_cycle(c + 1); wr_req = 0; set_wr(32'hDEAD_BEEF, 32'd99, 3'd0, BURST_FIXED);
        goto_cycle(c + 4); set_b(1); expect_ev(EV_WR_DONE, c + 5);
        goto_cycle(c + 5); set_b(0);
        goto_cycle(c + 7);
        check("write_id_after_done", 64'(write_id), 64'(1));
        check("write_cmd_held", {write_addr, write_len}, {32'h0, 32'd3});

        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();

        // Both requesters held after reset: write, read, write, read
        c = cyc;
        set_wr(32'h100, 32'd7, 3'd2, BURST_INCR); set_rd(32'h200, 32'd3, 3'd2, BURST_INCR);
        wr_req = 1; rd_req = 1;
        expect_cmd(EV_START_WR, c + 1, 32'h100, 32'd7, 3'd2, BURST_INCR, 4'd0);
        goto_cycle(c + 1); set_wr(32'h140, 32'd1, 3'd1, BURST_FIXED);
        goto_cycle(c + 2); set_b(1);
        expect_ev(EV_WR_DONE, c + 3);
        expect_cmd(EV_START_RD, c + 4, 32'h200, 32'd3, 3'd2, BURST_INCR, 4'd0);
        goto_cycle(c + 3); set_b(0);
        goto_cycle(c + 4); set_rd(32'h280, 32'd15, 3'd3, BURST_WRAP);
        goto_cycle(c + 5); set_r(1);
        expect_ev(EV_RD_DONE, c + 6);
        expect_cmd(EV_START_WR, c + 7, 32'h140, 32'd1, 3'd1, BURST_FIXED, 4'd1);
        goto_cycle(c + 6); set_r(0);
        goto_cycle(c + 7); wr_req = 0;
        goto_cycle(c + 8); set_b(1);
        expect_ev(EV_WR_DONE, c + 9);
        expect_cmd(EV_START_RD, c + 10, 32'h280, 32'd15, 3'd3, BURST_WRAP, 4'd1);
        goto_cycle(c + 9); set_b(0);
        goto_cycle(c + 10); rd_req = 0;
        goto_cycle(c + 11); set_r(1); expect_ev(EV_RD_DONE, c + 12);
        goto_cycle(c + 12); set_r(0);
        goto_cycle(c + 14);

        // Four-beat read with a leading non-handshake rlast; done after beat 4
        c = cyc;
        set_rd(32'h300, 32'd3, 3'd3, BURST_WRAP); rd_req = 1;
        expect_cmd(EV_START_RD, c + 1, 32'h300, 32'd3, 3'd3, BURST_WRAP, 4'd2);
        goto_cycle(c + 1); rd_req = 0;
        goto_cycle(c + 2); rvalid = 1; rready = 0; rlast = 1;
        goto_cycle(c + 3); rready = 1; rlast = 0;
        goto_cycle(c + 6); rlast = 1; expect_ev(EV_RD_DONE, c + 7);
        goto_cycle(c + 7); set_r(0);
        // Completions while idle are ignored
        goto_cycle(c + 8); set_b(1); set_r(1);
        goto_cycle(c + 9); set_b(0); set_r(0);
        goto_cycle(c + 11);

        // Stray B handshake while waiting on a read
        c = cyc;
        set_rd(32'h380, 32'd0, 3'd2, BURST_FIXED); rd_req = 1;
        expect_cmd(EV_START_RD, c + 1, 32'h380, 32'd0, 3'd2, BURST_FIXED, 4'd3);
        goto_cycle(c + 1); rd_req = 0;
        goto_cycle(c + 2); set_b(1);
        goto_cycle(c + 4); set_b(0); set_r(1); expect_ev(EV_RD_DONE, c + 5);
        goto_cycle(c + 5); set_r(0);
        goto_cycle(c + 7);
        check("write_id_after_stray_b", 64'(write_id), 64'(2));

        // Write timeout with a read pending; the read goes next
        c = cyc;
        set_wr(32'h400, 32'd7, 3'd2, BURST_INCR); wr_req = 1;
        expect_cmd(EV_START_WR, c + 1, 32'h400, 32'd7, 3'd2, BURST_INCR, 4'd2);
        goto_cycle(c + 1); wr_req = 0;
        set_rd(32'h500, 32'd1, 3'd2, BURST_INCR); rd_req = 1;
        expect_ev(EV_TIMEOUT, c + 18);
        expect_cmd(EV_START_RD, c + 19, 32'h500, 32'd1, 3'd2, BURST_INCR, 4'd4);
        goto_cycle(c + 19); rd_req = 0;
        goto_cycle(c + 20); set_r(1); expect_ev(EV_RD_DONE, c + 21);
        goto_cycle(c + 21); set_r(0);
        // Next write keeps the ID the timed-out burst used
        c = cyc;
        set_wr(32'h480, 32'd3, 3'd2, BURST_INCR); wr_req = 1;
        expect_cmd(EV_START_WR, c + 1, 32'h480, 32'd3, 3'd2, BURST_INCR, 4'd2);
        goto_cycle(c + 1); wr_req = 0;
        goto_cycle(c + 2); set_b(1); expect_ev(EV_WR_DONE, c + 3);
        goto_cycle(c + 3); set_b(0);
        goto_cycle(c + 5);

        // Completion on the expiry cycle counts as completion
        c = cyc;
        set_wr(32'h4C0, 32'd0, 3'd0, BURST_FIXED); wr_req = 1;
        expect_cmd(EV_START_WR, c + 1, 32'h4C0, 32'd0, 3'd0, BURST_FIXED, 4'd3);
        goto_cycle(c + 1); wr_req = 0;
        goto_cycle(c + 17); set_b(1); expect_ev(EV_WR_DONE, c + 18);
        goto_cycle(c + 18); set_b(0);
        goto_cycle(c + 20);

        // Reset during a read wait, then a contested request after release
        c = cyc;
        set_rd(32'h600, 32'd2, 3'd2, BURST_INCR); rd_req = 1;
        expect_cmd(EV_START_RD, c + 1, 32'h600, 32'd2, 3'd2, BURST_INCR, 4'd5);
        goto_cycle(c + 1); rd_req = 0;
        goto_cycle(c + 3);
        #2; rst_n = 1'b0; #1;
        check_all_zero("reset_in_wait_rd");
        check("queue_empty_at_reset", 64'(exp_q.size()), 64'(0));
        goto_cycle(c + 5); rst_n = 1'b1;
        c = cyc;
        set_wr(32'h700, 32'd5, 3'd2, BURST_INCR); set_rd(32'h800, 32'd6, 3'd2, BURST_INCR);
        wr_req = 1; rd_req = 1;
        expect_cmd(EV_START_WR, c + 1, 32'h700, 32'd5, 3'd2, BURST_INCR, 4'd0);
        goto_cycle(c + 1); wr_req = 0;
        goto_cycle(c + 2); set_b(1);
        expect_ev(EV_WR_DONE, c + 3);
        expect_cmd(EV_START_RD, c + 4, 32'h800, 32'd6, 3'd2, BURST_INCR, 4'd0);
        goto_cycle(c + 3); set_b(0);
        goto_cycle(c + 4); rd_req = 0;
        goto_cycle(c + 5); set_r(1); expect_ev(EV_RD_DONE, c + 6);
        goto_cycle(c + 6); set_r(0);
        goto_cycle(c + 10);

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_cmd_arbiter.md
MEM_CMD_ARBITER -- requirements
Module: mem_cmd_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_WIDTH, default 32, address width; ID_WIDTH, default 4, AXI ID width; TIMEOUT_CYCLES, default 1024, watchdog limit per burst.
REQ-002 The block SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 The block SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have ports: wr_req  in  1  write requester wants a burst; wr_addr/wr_len/wr_size/wr_burst  in  ADDR_WIDTH/32/3/2  write command.
REQ-005 The block SHALL have ports: rd_req  in  1  read requester wants a burst; rd_addr/rd_len/rd_size/rd_burst  in  ADDR_WIDTH/32/3/2  read command.
REQ-006 The block SHALL have ports: wr_grant, rd_grant  out  1  one-cycle acceptance pulses; wr_done, rd_done  out  1  one-cycle completion pulses.
REQ-007 The block SHALL have ports: start_write, start_read  out  1  one-cycle start pulses to the AXI master; write_addr/write_len/write_size/write_burst, read_addr/read_len/read_size/read_burst  out  ADDR_WIDTH/32/3/2  registered commands; write_id, read_id  out  ID_WIDTH  burst IDs.
REQ-008 The block SHALL have ports: bvalid, bready, rvalid, rready, rlast  in  1  AXI completion observation; timeout_err  out  1  one-cycle watchdog pulse.

Function
REQ-009 The FSM SHALL have states IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD; exactly one burst is outstanding at any time.
REQ-010 In IDLE with only wr_req=1, the next state SHALL be ISSUE_WR; with only rd_req=1, ISSUE_RD; with neither, IDLE.
REQ-011 With wr_req=1 and rd_req=1 in IDLE, the block SHALL grant round-robin: the requester not served last wins; after reset the writer wins.
REQ-012 On the IDLE->ISSUE_x edge, the block SHALL latch the x command into the x output registers; in ISSUE_x, start_x=1 and x_grant=1 for exactly one cycle, then WAIT_x.
REQ-013 Requesters SHALL hold req and command stable until grant; a req still high in IDLE after done SHALL be treated as a new request.
REQ-014 WAIT_WR SHALL end on the first cycle with bvalid&&bready; WAIT_RD SHALL end on the first cycle with rvalid&&rready&&rlast; the next cycle SHALL show x_done=1 with state IDLE.
REQ-015 Request-to-start latency SHALL be 1 cycle; completion-to-done latency SHALL be 1 cycle; idle gap between back-to-back bursts SHALL be 1 cycle (IDLE).
REQ-016 write_id SHALL increment modulo 2^ID_WIDTH after each write done; read_id likewise after each read done; timeouts SHALL NOT increment IDs.
REQ-017 A watchdog counter SHALL clear on entering WAIT_x and increment each WAIT_x cycle; on reaching TIMEOUT_CYCLES-1 without completion, timeout_err=1 for one cycle, the FSM SHALL return to IDLE, x_done SHALL NOT pulse, and round-robin SHALL treat x as served.
REQ-018 Completion and watchdog expiry in the same cycle SHALL count as completion (done pulses, no timeout_err).
REQ-019 Completion signals observed outside the matching WAIT state SHALL be ignored.
REQ-020 Command outputs SHALL hold their last latched value between bursts.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, last-served = reader (writer wins next), watchdog 0, IDs 0, all pulses and command outputs 0.
REQ-022 Reset mid-burst SHALL abandon the burst with no done and no timeout_err; the first post-reset request SHALL be granted normally.

Structure
REQ-023 A shared package SHALL hold the FSM state enum and the AXI burst encoding constants (FIXED=0, INCR=1, WRAP=2).
REQ-024 The watchdog SHALL be a sub-module burst_watchdog (clear, enable, expired) parameterised by TIMEOUT_CYCLES.

Verification
REQ-025 Single write: wr_req with wr_addr=0x0, wr_len=3 -> start_write and wr_grant one cycle later, write_addr=0x0, write_len=3, write_id=0; bvalid&&bready -> wr_done next cycle, then write_id=1.
REQ-026 Simultaneous wr_req and rd_req held after reset -> order write, read, write, read; each start 1 cycle after IDLE; one burst outstanding at a time.
REQ-027 Read with rvalid&&rready for 4 beats, rlast on beat 4 -> rd_done exactly 1 cycle after beat 4, not earlier.
REQ-028 TIMEOUT_CYCLES=16, write granted, no bvalid -> timeout_err exactly 16 cycles after entering WAIT_WR, no wr_done, write_id unchanged, pending rd_req granted next.
REQ-029 rst_n asserted in WAIT_RD -> all outputs 0 immediately; after release, wr_req and rd_req together -> writer granted first.
REQ-030 Stray bvalid&&bready during WAIT_RD -> no wr_done, state unchanged.
